aes_iterative_encrypt_ctrl: RTL and testbench

//  Sequential AES encryption engine: one round datapath reused over Nr+1 clock edges,

---
 rtl/aes_iterative_encrypt_ctrl.sv | 157 +++++++++++++++
 tb/tb_aes_iterative_encrypt_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iterative_encrypt_ctrl.sv
// Iterative AES encryption engine: a single round datapath is reused over Nr+1 clock edges,
// reading round keys from the expanded key bus and reporting completion with a done pulse.
module aes_iterative_encrypt_ctrl #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [127:0]          in_msg,
    input  logic [128*(Nr+1)-1:0] w,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            round,
    output logic [127:0]          out_msg
);

    if (Nr != Nk + 6) begin : g_bad_cfg
        $error("aes_iterative_encrypt_ctrl: Nr must equal Nk+6");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [3:0] NR4     = 4'(Nr);

    logic [1:0]   r_fsm;
    logic [127:0] r_data;
    logic [3:0]   r_round;
    logic         r_busy;
    logic         r_done;
    logic [127:0] r_out;

    logic [127:0] w_rk [0:15];
    logic [127:0] w_rk_cur;
    logic [127:0] w_sr;
    logic [127:0] w_mix;
    logic [3:0]   w_round_nxt;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte n of the state sits at [127-8n -: 8]; byte n is row n%4, column n/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Round-key select is a plain mux on the 4-bit round index; unused slots read as zero.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rk
        if (gi <= Nr) begin : g_used
            assign w_rk[gi] = w[128*(Nr+1)-1-128*gi -: 128];
        end else begin : g_pad
            assign w_rk[gi] = '0;
        end
    end

    assign w_rk_cur    = w_rk[r_round];
    assign w_sr        = sub_shift(r_data);
    assign w_mix       = mix_columns(w_sr);
    assign w_round_nxt = r_round + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm   <= S_IDLE;
            r_data  <= '0;
            r_round <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_data  <= in_msg ^ w_rk[0];
                        r_round <= 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= (NR4 == 4'd1) ? S_FINAL : S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_data  <= w_mix ^ w_rk_cur;
                    r_round <= w_round_nxt;
                    if (w_round_nxt == NR4) r_fsm <= S_FINAL;
                end
                S_FINAL: begin
                    r_out   <= w_sr ^ w_rk_cur;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_round <= '0;
                    r_fsm   <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign round   = r_round;
    assign out_msg = r_out;

endmodule

// File: tb/tb_aes_iterative_encrypt_ctrl.sv
// Bench for aes_iterative_encrypt_ctrl: AES-128 and AES-256 instances checked against FIPS-197 /
// SP 800-38A ciphertexts through a scoreboard, plus handshake, reset and done-pulse sequences.
module tb_aes_iterative_encrypt_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b1;
    logic            start_a, start_b;
    logic [127:0]    msg_a, msg_b;
    logic [1407:0]   w_a;
    logic [1919:0]   w_b;
    logic            busy_a, busy_b, done_a, done_b;
    logic [3:0]      round_a, round_b;
    logic [127:0]    out_a, out_b;

    aes_iterative_encrypt_ctrl #(.Nk(4), .Nr(10)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_msg(msg_a), .w(w_a),
        .busy(busy_a), .done(done_a), .round(round_a), .out_msg(out_a)
    );

    aes_iterative_encrypt_ctrl #(.Nk(8), .Nr(14)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_msg(msg_b), .w(w_b),
        .busy(busy_b), .done(done_b), .round(round_b), .out_msg(out_b)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference S-box built by walking the multiplicative group with generator 3.
    logic [7:0] sb [0:255];
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Key expansion; word i lands at [1919-32*i -: 32], so round key 0 is the top 128 bits.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   wd [0:59];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] r;
        int            nw;
        nw   = 4 * (nk + 7);
        rcon = 8'h01;
        r    = '0;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) r[1919-32*i -: 32] = wd[i];
        return r;
    endfunction

    // Scoreboard: expected ciphertext and accept cycle pushed on each accepted start.
    logic [127:0] exp_a, exp_b;
    logic [127:0] sb_a [$];
    logic [127:0] sb_b [$];
    int           acc_a [$];
    int           acc_b [$];
    int           done_cnt_a = 0;
    int           done_cnt_b = 0;
    int           last_done_a = 0;

    always @(negedge clk) begin
        if (done_a) begin
            done_cnt_a++;
            last_done_a = cyc;
            chk("sb_a_nonempty", 128'(sb_a.size() > 0), 128'd1);
            if (sb_a.size() > 0) begin
                chk("ct_a", out_a, sb_a.pop_front());
                chk("latency_a", 128'(cyc - acc_a.pop_front()), 128'd10);
                chk("busy_a_at_done", 128'(busy_a), 128'd0);
            end
        end
        if (done_b) begin
            done_cnt_b++;
            chk("sb_b_nonempty", 128'(sb_b.size() > 0), 128'd1);
            if (sb_b.size() > 0) begin
                chk("ct_b", out_b, sb_b.pop_front());
                chk("latency_b", 128'(cyc - acc_b.pop_front()), 128'd14);
            end
        end
        if (!reset && start_a && !busy_a) begin
            sb_a.push_back(exp_a);
            acc_a.push_back(cyc + 1);
        end
        if (!reset && start_b && !busy_b) begin
            sb_b.push_back(exp_b);
            acc_b.push_back(cyc + 1);
        end
    end

    typedef struct {
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        bit           wide;
    } vec_t;
    vec_t vecs [5];

    localparam logic [255:0] KEY_A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    task automatic load_a(input logic [255:0] key);
        logic [1919:0] full;
        full = expand(key, 4);
        w_a  = full[1919 -: 1408];
    endtask

    task automatic wait_a(input int tgt, input int budget, input string name);
        for (int i = 0; i < budget && done_cnt_a < tgt; i++) step();
        chk(name, 128'(done_cnt_a), 128'(tgt));
    endtask

    task automatic run_vec(input vec_t v);
        int n0;
        if (!v.wide) begin
            load_a(v.key);
            msg_a = v.pt; exp_a = v.ct; start_a = 1'b1;
            n0 = done_cnt_a;
            step();
            start_a = 1'b0;
            chk("busy_a_after_accept", 128'(busy_a), 128'd1);
            chk("round_a_after_accept", 128'(round_a), 128'd1);
            wait_a(n0 + 1, 30, "done_a_seen");
            chk("done_a_one_cycle", 128'(done_a), 128'd0);
        end else begin
            w_b   = expand(v.key, 8);
            msg_b = v.pt; exp_b = v.ct; start_b = 1'b1;
            n0 = done_cnt_b;
            step();
            start_b = 1'b0;
            chk("busy_b_after_accept", 128'(busy_b), 128'd1);
            for (int i = 0; i < 40 && done_cnt_b < n0 + 1; i++) step();
            chk("done_b_seen", 128'(done_cnt_b), 128'(n0 + 1));
            chk("done_b_one_cycle", 128'(done_b), 128'd0);
        end
        step();
    endtask

    initial begin
        int n0, d1, changes, dhigh;
        logic [127:0] held;

        build_sbox();
        start_a = 1'b0; start_b = 1'b0;
        msg_a = '0; msg_b = '0; w_a = '0; w_b = '0;
        exp_a = '0; exp_b = '0;

        vecs[0] = '{KEY_A, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
        vecs[1] = '{KEY_B, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b0};
        vecs[2] = '{KEY_B, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b0};
        vecs[3] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h8ea2b7ca516745bfeafc49904b496089, 1'b1};
        vecs[4] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    128'h6bc1bee22e409f96e93d7e117393172a,
                    128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 1'b1};

        repeat (3) step();
        chk("rst_busy_a", 128'(busy_a), 128'd0);
        chk("rst_done_a", 128'(done_a), 128'd0);
        chk("rst_round_a", 128'(round_a), 128'd0);
        chk("rst_out_a", out_a, 128'd0);
        chk("rst_busy_b", 128'(busy_b), 128'd0);
        chk("rst_out_b", out_b, 128'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // start held high: second block accepted in the done cycle of the first
        load_a(KEY_B);
        msg_a = vecs[1].pt; exp_a = vecs[1].ct; start_a = 1'b1;
        n0 = done_cnt_a;
        step();
        msg_a = vecs[2].pt; exp_a = vecs[2].ct;
        wait_a(n0 + 1, 30, "held_first_done");
        d1 = last_done_a;
        start_a = 1'b0;
        wait_a(n0 + 2, 30, "held_second_done");
        chk("held_done_spacing", 128'(last_done_a - d1), 128'd11);
        step();

        // start pulsed mid-run with a different message must be ignored
        load_a(KEY_A);
        msg_a = vecs[0].pt; exp_a = vecs[0].ct; start_a = 1'b1;
        n0 = done_cnt_a;
        step();
        start_a = 1'b0;
        repeat (4) step();
        chk("round_a_is_5", 128'(round_a), 128'd5);
        msg_a = ~vecs[0].pt; exp_a = 128'hbad0bad0bad0bad0bad0bad0bad0bad0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_a(n0 + 1, 30, "ignore_done");
        repeat (20) step();
        chk("ignore_single_done", 128'(done_cnt_a), 128'(n0 + 1));

        // asynchronous reset in round 6
        exp_a = vecs[0].ct; msg_a = vecs[0].pt; start_a = 1'b1;
        n0 = done_cnt_a;
        step();
        start_a = 1'b0;
        repeat (5) step();
        chk("round_a_is_6", 128'(round_a), 128'd6);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", 128'(busy_a), 128'd0);
        chk("async_rst_round", 128'(round_a), 128'd0);
        chk("async_rst_done", 128'(done_a), 128'd0);
        chk("async_rst_out", out_a, 128'd0);
        sb_a.delete();
        acc_a.delete();
        repeat (3) step();
        reset = 1'b0;
        repeat (15) step();
        chk("no_done_after_rst", 128'(done_cnt_a), 128'(n0));
        run_vec(vecs[0]);

        // done pulse width and ciphertext hold over 20 idle cycles
        held = out_a;
        changes = 0;
        dhigh = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_a !== held) changes++;
            if (done_a) dhigh++;
        end
        chk("out_hold_changes", 128'(changes), 128'd0);
        chk("idle_done_high", 128'(dhigh), 128'd0);
        chk("out_held_value", out_a, vecs[0].ct);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
